bbox_scanner: RTL and testbench

BBOX_SCANNER -- requirements
Module: bbox_scanner

---
 rtl/bbox_scanner.sv | 194 +++++++++++++++++++
 tb/tb_bbox_scanner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bbox_scanner.sv
// rtl/bbox_scanner.sv - bounding-box raster scanner for triangle pixel generation
//
// Accepts a triangle (three 16-bit unsigned vertices) on a tri_nd/tri_rfd
// handshake, computes its axis-aligned bounding box in a one-cycle SETUP
// state, then emits every pixel of the box in raster order on a
// px_nd/ds_rfd handshake.  px_last marks the final pixel.
//
// Optional feature macro: SCAN_CLIP_EN
//   defined   - box is clamped to SCREEN_W x SCREEN_H; a box lying wholly off
//               screen emits no pixels and pulses tri_empty during SETUP.
//   undefined - no clamping, tri_empty is tied low.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   tri_nd / tri_rfd          triangle valid / ready
//   v1_x..v3_y                incoming vertex coordinates
//   ds_rfd                    downstream ready
//   px_nd, p_x, p_y, px_last  pixel valid, coordinates, last-pixel flag
//   o_v1_x..o_v3_y            vertices latched at acceptance
//   tri_empty                 one-cycle pulse for a triangle with no pixels
module bbox_scanner #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tri_nd,
    output logic        tri_rfd,
    input  logic [15:0] v1_x,
    input  logic [15:0] v1_y,
    input  logic [15:0] v2_x,
    input  logic [15:0] v2_y,
    input  logic [15:0] v3_x,
    input  logic [15:0] v3_y,
    input  logic        ds_rfd,
    output logic        px_nd,
    output logic [15:0] p_x,
    output logic [15:0] p_y,
    output logic [15:0] o_v1_x,
    output logic [15:0] o_v1_y,
    output logic [15:0] o_v2_x,
    output logic [15:0] o_v2_y,
    output logic [15:0] o_v3_x,
    output logic [15:0] o_v3_y,
    output logic        px_last,
    output logic        tri_empty
);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

    state_t      state;
    logic [15:0] xmin, xmax, ymin, ymax;

    function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Bounds derived from the latched vertices, registered in SETUP.
    logic [15:0] s_xmin, s_xmax, s_ymin, s_ymax;
    logic [15:0] raw_xmax, raw_ymax;

    assign s_xmin   = min3(o_v1_x, o_v2_x, o_v3_x);
    assign s_ymin   = min3(o_v1_y, o_v2_y, o_v3_y);
    assign raw_xmax = max3(o_v1_x, o_v2_x, o_v3_x);
    assign raw_ymax = max3(o_v1_y, o_v2_y, o_v3_y);

`ifdef SCAN_CLIP_EN
    localparam logic [15:0] X_LIM = 16'(SCREEN_W - 1);
    localparam logic [15:0] Y_LIM = 16'(SCREEN_H - 1);

    // Off-screen test is made on the incoming vertices so that the
    // registered tri_empty is already high during the SETUP cycle.
    logic in_empty;
    assign in_empty = (min3(v1_x, v2_x, v3_x) > X_LIM) || (min3(v1_y, v2_y, v3_y) > Y_LIM);

    assign s_xmax = (raw_xmax > X_LIM) ? X_LIM : raw_xmax;
    assign s_ymax = (raw_ymax > Y_LIM) ? Y_LIM : raw_ymax;
`else
    assign s_xmax    = raw_xmax;
    assign s_ymax    = raw_ymax;
    assign tri_empty = 1'b0;

    logic unused_screen;
    assign unused_screen = ^{SCREEN_W[0], SCREEN_H[0]};
`endif

    // Next raster position; equality against the bounds means a box ending
    // at 65535 never needs an increment past it.
    logic        x_wrap;
    logic [15:0] nx, ny;

    assign x_wrap = (p_x == xmax);
    assign nx     = x_wrap ? xmin : p_x + 16'd1;
    assign ny     = x_wrap ? p_y + 16'd1 : p_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tri_rfd <= 1'b1;
            px_nd   <= 1'b0;
            px_last <= 1'b0;
            p_x     <= '0;
            p_y     <= '0;
            xmin    <= '0;
            xmax    <= '0;
            ymin    <= '0;
            ymax    <= '0;
            o_v1_x  <= '0;
            o_v1_y  <= '0;
            o_v2_x  <= '0;
            o_v2_y  <= '0;
            o_v3_x  <= '0;
            o_v3_y  <= '0;
`ifdef SCAN_CLIP_EN
            tri_empty <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tri_rfd <= 1'b1;
                    px_nd   <= 1'b0;
                    px_last <= 1'b0;
                    if (tri_nd) begin
                        o_v1_x  <= v1_x;
                        o_v1_y  <= v1_y;
                        o_v2_x  <= v2_x;
                        o_v2_y  <= v2_y;
                        o_v3_x  <= v3_x;
                        o_v3_y  <= v3_y;
                        tri_rfd <= 1'b0;
                        state   <= SETUP;
`ifdef SCAN_CLIP_EN
                        tri_empty <= in_empty;
`endif
                    end
                end

                SETUP: begin
                    xmin <= s_xmin;
                    xmax <= s_xmax;
                    ymin <= s_ymin;
                    ymax <= s_ymax;
`ifdef SCAN_CLIP_EN
                    tri_empty <= 1'b0;
                    if (tri_empty) begin
                        tri_rfd <= 1'b1;
                        state   <= IDLE;
                    end else
`endif
                    begin
                        p_x     <= s_xmin;
                        p_y     <= s_ymin;
                        px_nd   <= 1'b1;
                        px_last <= (s_xmin == s_xmax) && (s_ymin == s_ymax);
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (ds_rfd) begin
                        if (px_last) begin
                            px_nd   <= 1'b0;
                            px_last <= 1'b0;
                            tri_rfd <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            p_x     <= nx;
                            p_y     <= ny;
                            px_last <= (nx == xmax) && (ny == ymax);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    tri_rfd <= 1'b1;
                    px_nd   <= 1'b0;
                    px_last <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scanner.sv
// tb/tb_bbox_scanner.sv - directed self-checking bench for bbox_scanner
module tb_bbox_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_nd;
    logic        tri_rfd;
    logic [15:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic        ds_rfd;
    logic        px_nd;
    logic [15:0] p_x, p_y;
    logic [15:0] o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y;
    logic        px_last;
    logic        tri_empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bbox_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .tri_nd    (tri_nd),
        .tri_rfd   (tri_rfd),
        .v1_x      (v1_x),
        .v1_y      (v1_y),
        .v2_x      (v2_x),
        .v2_y      (v2_y),
        .v3_x      (v3_x),
        .v3_y      (v3_y),
        .ds_rfd    (ds_rfd),
        .px_nd     (px_nd),
        .p_x       (p_x),
        .p_y       (p_y),
        .o_v1_x    (o_v1_x),
        .o_v1_y    (o_v1_y),
        .o_v2_x    (o_v2_x),
        .o_v2_y    (o_v2_y),
        .o_v3_x    (o_v3_x),
        .o_v3_y    (o_v3_y),
        .px_last   (px_last),
        .tri_empty (tri_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one triangle and wait (bounded) for the acceptance edge.
    // Returns at the negedge of the SETUP cycle.
    task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
        int w;
        w = 0;
        while (!tri_rfd && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rfd_before_accept", tri_rfd, 1);
        v1_x = 16'(ax); v1_y = 16'(ay);
        v2_x = 16'(bx); v2_y = 16'(by);
        v3_x = 16'(cx); v3_y = 16'(cy);
        tri_nd = 1'b1;
        @(negedge clk);
        tri_nd = 1'b0;
        check("setup_rfd", tri_rfd, 0);
        check("setup_nd", px_nd, 0);
        check("latched_v2_x", o_v2_x, 32'(bx));
        check("latched_v3_y", o_v3_y, 32'(cy));
    endtask

    // Scan the expected box; toggle selects ds_rfd 1/0 alternation,
    // stop_after>0 ends the scan after that many transfers.
    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy,
                           input int xmin, input int xmax, input int ymin, input int ymax,
                           input bit toggle, input int stop_after);
        int n, lim, k, cyc, ex, ey;
        bit ds;
        n   = (xmax - xmin + 1) * (ymax - ymin + 1);
        lim = (stop_after > 0) ? stop_after : n;
        send_tri(ax, ay, bx, by, cx, cy);
        check("setup_empty", tri_empty, 0);
        @(negedge clk);
        check("first_nd", px_nd, 1);
        k = 0; cyc = 0; ex = xmin; ey = ymin;
        while (k < lim && cyc < 4 * n + 20) begin
            ds = toggle ? ~cyc[0] : 1'b1;
            ds_rfd = ds;
            check("px_nd", px_nd, 1);
            check("p_x", p_x, 32'(ex));
            check("p_y", p_y, 32'(ey));
            check("px_last", px_last, 32'((ex == xmax) && (ey == ymax)));
            check("v1_x_stable", o_v1_x, 32'(ax));
            if (ds) begin
                k++;
                if (ex == xmax) begin
                    ex = xmin;
                    ey++;
                end else begin
                    ex++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        check("pixel_count", k, lim);
        ds_rfd = 1'b1;
        if (stop_after == 0) begin
            check("end_nd", px_nd, 0);
            check("end_rfd", tri_rfd, 1);
            check("end_last", px_last, 0);
        end
    endtask

    initial begin
        rst = 1'b1; tri_nd = 1'b0; ds_rfd = 1'b1;
        v1_x = 0; v1_y = 0; v2_x = 0; v2_y = 0; v3_x = 0; v3_y = 0;
        repeat (2) @(negedge clk);
        check("rst_rfd", tri_rfd, 1);
        check("rst_nd", px_nd, 0);
        check("rst_last", px_last, 0);
        check("rst_empty", tri_empty, 0);
        check("rst_px", p_x, 0);
        check("rst_py", p_y, 0);
        check("rst_ov1x", o_v1_x, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic triangle, ds always ready: box 2..4 x 3..5.
        run_tri(2, 3, 4, 3, 3, 5, 2, 4, 3, 5, 1'b0, 0);
        // Same triangle under back-pressure.
        run_tri(2, 3, 4, 3, 3, 5, 2, 4, 3, 5, 1'b1, 0);
        // Degenerate single-pixel triangle.
        run_tri(7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 1'b0, 0);

        // Reset after the fourth pixel, with tri_nd and ds_rfd both high.
        run_tri(2, 3, 4, 3, 3, 5, 2, 4, 3, 5, 1'b0, 4);
        rst = 1'b1; tri_nd = 1'b1; ds_rfd = 1'b1;
        @(negedge clk);
        check("midrst_nd", px_nd, 0);
        check("midrst_rfd", tri_rfd, 1);
        check("midrst_px", p_x, 0);
        check("midrst_ov", o_v2_x, 0);
        rst = 1'b0; tri_nd = 1'b0;
        @(negedge clk);
        check("post_rst_nd", px_nd, 0);
        run_tri(10, 20, 11, 20, 10, 20, 10, 11, 20, 20, 1'b0, 0);

`ifdef SCAN_CLIP_EN
        // Clamped to the bottom-right 2x2 corner of the screen.
        run_tri(638, 478, 700, 478, 638, 500, 638, 639, 478, 479, 1'b0, 0);
        // Wholly right of the screen: empty.
        send_tri(700, 10, 710, 10, 705, 20);
        check("empty_pulse", tri_empty, 1);
        @(negedge clk);
        check("empty_drop", tri_empty, 0);
        check("empty_nd", px_nd, 0);
        check("empty_rfd", tri_rfd, 1);
        @(negedge clk);
        check("empty_nd2", px_nd, 0);
`else
        // Box touching 65535 on both axes: no wrap, four pixels.
        run_tri(65534, 65534, 65535, 65535, 65535, 65534, 65534, 65535, 65534, 65535, 1'b1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
